// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC select codes,
// FSM state encoding and the default idle instruction word.
package instr_fetch_unit_pkg;

  // Next-PC select encodings driven by the decoder on pcsrc
  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;

  // addi x0,x0,0 -- presented on instr while nothing has been fetched
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch FSM states
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    TRAP  = 2'd3
  } state_e;

endpackage

// File: rtl/instr_fetch_unit_pc_next_logic.sv
// Next-PC computation: selects pc+4, branch target or JALR target and flags
// targets that are not word aligned. Purely combinational, no state.
module pc_next_logic
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [1:0]  pcsrc_i,
  input  logic [31:0] immext_i,
  input  logic [31:0] alu_result_i,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);

  // Three-way target select; the reserved code falls back to sequential flow.
  // JALR clears bit 0 of the ALU result before the alignment check, so only
  // a set bit 1 can make a JALR target misaligned.
  always_comb begin
    next_pc_o = pc_i + 32'd4;
    case (pcsrc_i)
      PCSRC_BRANCH: next_pc_o = pc_i + immext_i;
      PCSRC_JALR:   next_pc_o = alu_result_i & ~32'h1;
      default:      next_pc_o = pc_i + 32'd4;
    endcase
    misaligned_o = (next_pc_o[1:0] != 2'b00);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests one word at pc, holds it for the decoder
// until accepted, then steps pc. Traps permanently on a misaligned target.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = instr_fetch_unit_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] immext,
  input  logic [31:0] alu_result,
  output logic        misaligned
);

  state_e      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        misaligned_q;

  logic [31:0] nxt_pc;
  logic        nxt_misaligned;
  logic        ack_take;
  logic        accept;

  pc_next_logic u_pc_next (
    .pc_i         (pc_q),
    .pcsrc_i      (pcsrc),
    .immext_i     (immext),
    .alu_result_i (alu_result),
    .next_pc_o    (nxt_pc),
    .misaligned_o (nxt_misaligned)
  );

  // State register; reset restarts fetching regardless of what is in flight
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic: request until ack, hold until accepted, trap is terminal
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = imem_ack ? HOLD : WAIT;
      WAIT:    if (imem_ack) state_d = HOLD;
      HOLD:    if (instr_ready) state_d = nxt_misaligned ? TRAP : FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // Output decode; the request is masked during reset so an abandoned fetch
  // is never re-issued in the reset cycle itself
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    ack_take    = 1'b0;
    accept      = 1'b0;
    case (state_q)
      FETCH, WAIT: begin
        imem_req = ~rst;
        ack_take = imem_ack;
      end
      HOLD: begin
        instr_valid = 1'b1;
        accept      = instr_ready;
      end
      default: ;
    endcase
  end

  // Datapath: capture the fetched word, step pc on accept, latch the trap flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      misaligned_q <= 1'b0;
    end else begin
      if (ack_take) instr_q <= imem_rdata;
      if (accept) begin
        if (nxt_misaligned) misaligned_q <= 1'b1;
        else                pc_q         <= nxt_pc;
      end
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_q + 32'd4;
  assign instr      = instr_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, latency, stall, next-PC
// selection, wraparound, trap and reset-recovery scenarios.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  pcsrc;
  logic [31:0] immext;
  logic [31:0] alu_result;
  logic        misaligned;

  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .pcsrc       (pcsrc),
    .immext      (immext),
    .alu_result  (alu_result),
    .misaligned  (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-latency fetch from FETCH; leaves the unit in HOLD
  task automatic fetch0(input logic [31:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
  endtask

  // Accept the held instruction with the given next-PC controls
  task automatic accept(input logic [1:0] sel, input logic [31:0] imm, input logic [31:0] alu);
    instr_ready = 1'b1;
    pcsrc       = sel;
    immext      = imm;
    alu_result  = alu;
    tick();
    instr_ready = 1'b0;
    pcsrc       = 2'b00;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    pcsrc = 2'b00; immext = 32'h0; alu_result = 32'h0;

    // Reset state
    tick();
    chk("rst_req",   {31'b0, imem_req},    32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr,                32'h0000_0013);
    chk("rst_pc",    pc,                   32'h0);
    chk("rst_mis",   {31'b0, misaligned},  32'h0);

    // Zero-latency fetch, valid on the second cycle, sequential next address
    rst = 1'b0; #1;
    chk("c1_req",  {31'b0, imem_req}, 32'h1);
    chk("c1_addr", imem_addr,         32'h0);
    fetch0(32'h0050_0093);
    chk("c2_valid", {31'b0, instr_valid}, 32'h1);
    chk("c2_instr", instr,                32'h0050_0093);
    chk("c2_req",   {31'b0, imem_req},    32'h0);
    chk("c2_pc4",   pc_plus4,             32'h4);
    accept(2'b00, 32'h0, 32'h0);
    chk("seq_addr",  imem_addr,            32'h4);
    chk("seq_valid", {31'b0, instr_valid}, 32'h0);

    // Ack delayed by three cycles: request held four cycles at a fixed address
    for (int i = 0; i < 3; i++) begin
      chk("wait_req",  {31'b0, imem_req}, 32'h1);
      chk("wait_addr", imem_addr,         32'h4);
      tick();
    end
    chk("wait_req4",  {31'b0, imem_req}, 32'h1);
    chk("wait_addr4", imem_addr,         32'h4);
    fetch0(32'hDEAD_BEEF);
    // Stall in HOLD; a stray ack here must not overwrite instr
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'b0, instr_valid}, 32'h1);
      chk("hold_instr", instr,                32'hDEAD_BEEF);
      chk("hold_pc",    pc,                   32'h4);
      tick();
    end
    imem_ack = 1'b0;
    accept(2'b01, 32'h0000_000C, 32'h0);
    chk("br_fwd_pc", pc, 32'h10);

    // Backward branch
    fetch0(32'h0000_0013);
    accept(2'b01, 32'hFFFF_FFF8, 32'h0);
    chk("br_back_pc", pc,        32'h8);
    chk("br_back_ad", imem_addr, 32'h8);

    // JALR with bit 0 set: cleared, still aligned
    fetch0(32'h0000_0013);
    accept(2'b10, 32'h0, 32'h0000_0201);
    chk("jalr201_pc",  pc,                  32'h200);
    chk("jalr201_mis", {31'b0, misaligned}, 32'h0);
    fetch0(32'h0000_0013);
    accept(2'b10, 32'h0, 32'h0000_0105);
    chk("jalr105_pc",  pc,                  32'h104);
    chk("jalr105_mis", {31'b0, misaligned}, 32'h0);

    // Wraparound at the top of the address space, then reserved select
    fetch0(32'h0000_0013);
    accept(2'b01, 32'hFFFF_FEF8, 32'h0);
    chk("top_pc", pc, 32'hFFFF_FFFC);
    fetch0(32'h0000_0013);
    chk("top_pc4", pc_plus4, 32'h0);
    accept(2'b00, 32'h0, 32'h0);
    chk("wrap_pc",  pc,                  32'h0);
    chk("wrap_mis", {31'b0, misaligned}, 32'h0);
    fetch0(32'h0000_0013);
    accept(2'b11, 32'h0000_0100, 32'h0000_0800);
    chk("rsv_pc", pc, 32'h4);

    // Misaligned JALR target: trap with pc unchanged
    fetch0(32'h0000_0013);
    accept(2'b10, 32'h0, 32'h0000_0106);
    chk("trap_mis",   {31'b0, misaligned},  32'h1);
    chk("trap_req",   {31'b0, imem_req},    32'h0);
    chk("trap_valid", {31'b0, instr_valid}, 32'h0);
    chk("trap_pc",    pc,                   32'h4);
    imem_ack = 1'b1; instr_ready = 1'b1; imem_rdata = 32'h2222_2222;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("trap_stay_req",   {31'b0, imem_req},    32'h0);
      chk("trap_stay_valid", {31'b0, instr_valid}, 32'h0);
    end
    imem_ack = 1'b0; instr_ready = 1'b0;

    // Reset out of TRAP clears the flag
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("untrap_mis", {31'b0, misaligned}, 32'h0);
    chk("untrap_pc",  pc,                  32'h0);
    chk("untrap_req", {31'b0, imem_req},   32'h1);

    // Reset in WAIT with a coincident ack: response discarded
    tick();
    chk("w_req", {31'b0, imem_req}, 32'h1);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D; #1;
    chk("w_rst_req", {31'b0, imem_req}, 32'h0);
    tick();
    rst = 1'b0; imem_ack = 1'b0; #1;
    chk("w_rst_instr", instr,                32'h0000_0013);
    chk("w_rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("w_rst_addr",  imem_addr,            32'h0);
    chk("w_rst_req2",  {31'b0, imem_req},    32'h1);
    tick();
    chk("w_after_valid", {31'b0, instr_valid}, 32'h0);
    chk("w_after_req",   {31'b0, imem_req},    32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
